arith_accum: RTL and testbench

Sequential operand sequencer and accumulator wrapped around the team's combinational 8-bit add/subtract block `arith`. It accepts a frame of N_OPS signed 8-bit operands over a valid/ready handshake. For each operand it drives `arith` with (accumulator, operand, op_sub) and registers SUM back into the accumulator. Overflow is optionally saturated and is also recorded in a sticky flag. It sits upstream of `arith`, feeding A/B/SUB, and downstream of it, consuming SUM/OV.

---
 rtl/arith_accum_if.sv | 11 +
 rtl/arith_accum.sv | 106 ++++++++++
 tb/tb_arith_accum.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/arith_accum_if.sv
// Operand handshake bundle between an operand source and arith_accum.
// The source drives valid, data and the add/subtract select; the accumulator drives ready.
interface arith_accum_if;
  logic               op_vld;
  logic               op_rdy;
  logic signed [7:0]  op_data;
  logic               op_sub;

  modport master (output op_vld, output op_data, output op_sub, input op_rdy);
  modport slave  (input op_vld, input op_data, input op_sub, output op_rdy);
endinterface

// File: rtl/arith_accum.sv
// Frame-based operand sequencer/accumulator around the combinational 8-bit add/subtract block arith.
// Each accepted operand folds into the accumulator; overflow saturates (SAT=1) or wraps and is made sticky.
module arith (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic              sub,
  output logic signed [7:0] sum,
  output logic              ov
);
  logic [7:0] bx;

  always_comb begin
    bx  = sub ? ~b : b;
    sum = a + bx + {7'd0, sub};
    // Overflow when both addends share a sign and the result sign differs.
    ov  = (a[7] == bx[7]) && (sum[7] != a[7]);
  end
endmodule

module arith_accum #(
  parameter int N_OPS = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [7:0]  init,
  arith_accum_if.slave       op,
  output logic signed [7:0]  acc,
  output logic               ovf,
  output logic [3:0]         cnt,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic signed [7:0] sum;
  logic              ov;
  logic              accept;
  logic              last;

  function automatic logic signed [7:0] sat_result(input logic signed [7:0] a,
                                                   input logic signed [7:0] s,
                                                   input logic              o);
    // On overflow the true result carries the sign of the accumulator operand.
    if (o && SAT) sat_result = a[7] ? 8'sh80 : 8'sh7F;
    else          sat_result = s;
  endfunction

  arith u_arith (
    .a   (acc),
    .b   (op.op_data),
    .sub (op.op_sub),
    .sum (sum),
    .ov  (ov)
  );

  // A start in RUN restarts the frame and swallows any operand offered that cycle.
  assign accept = (state == RUN) && op.op_vld && !start;
  assign last   = (cnt == 4'(N_OPS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op.op_rdy = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        op.op_rdy = 1'b1;
        busy      = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator stage: load on start, fold on accept, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 8'sh00;
      ovf <= 1'b0;
      cnt <= 4'd0;
    end else if (start && (state != DONE)) begin
      acc <= init;
      ovf <= 1'b0;
      cnt <= 4'd0;
    end else if (accept) begin
      acc <= sat_result(acc, sum, ov);
      ovf <= ovf | ov;
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_arith_accum.sv
// Scoreboard bench for arith_accum: saturating and wrapping instances share one operand stream.
// The driver queues expected accumulator state per operand and per frame end; a monitor pops on accept and on done.
module tb_arith_accum;
  typedef struct packed {
    logic [7:0] acc;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] init;

  logic signed [7:0] acc_s, acc_w;
  logic              ovf_s, ovf_w;
  logic [3:0]        cnt_s, cnt_w;
  logic              busy_s, busy_w;
  logic              done_s, done_w;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t done_q[$];

  arith_accum_if bus_s ();
  arith_accum_if bus_w ();

  assign bus_w.op_vld  = bus_s.op_vld;
  assign bus_w.op_data = bus_s.op_data;
  assign bus_w.op_sub  = bus_s.op_sub;

  arith_accum #(.N_OPS(4), .SAT(1'b1)) dut_s (
    .clk (clk), .rst (rst), .start (start), .init (init), .op (bus_s.slave),
    .acc (acc_s), .ovf (ovf_s), .cnt (cnt_s), .busy (busy_s), .done (done_s)
  );

  arith_accum #(.N_OPS(4), .SAT(1'b0)) dut_w (
    .clk (clk), .rst (rst), .start (start), .init (init), .op (bus_w.slave),
    .acc (acc_w), .ovf (ovf_w), .cnt (cnt_w), .busy (busy_w), .done (done_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] v);
    start = 1'b1;
    init  = v;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sub,
                      input logic [7:0] ea, input logic eo, input logic [3:0] ec);
    int n = 0;
    while (!bus_s.op_rdy && n < 20) begin
      step();
      n++;
    end
    if (!bus_s.op_rdy) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout actual=0 required=1");
    end else begin
      bus_s.op_vld  = 1'b1;
      bus_s.op_data = d;
      bus_s.op_sub  = sub;
      exp_q.push_back('{acc: ea, ovf: eo, cnt: ec});
      step();
      bus_s.op_vld = 1'b0;
    end
  endtask

  // Monitor: handshake sampled mid-cycle, registered results compared just after the edge.
  initial begin
    logic acc_p;
    exp_t e;
    forever begin
      @(negedge clk);
      acc_p = bus_s.op_vld && bus_s.op_rdy && !rst && !start;
      @(posedge clk);
      #1;
      if (acc_p) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_unexpected actual=%0h required=none", {acc_s, ovf_s, cnt_s});
        end else begin
          e = exp_q.pop_front();
          check("accept_state", 32'({acc_s, ovf_s, cnt_s}), 32'(e));
        end
      end
      if (done_s) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          e = done_q.pop_front();
          check("done_state", 32'({acc_s, ovf_s, cnt_s}), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; init = 8'h00;
    bus_s.op_vld = 1'b0; bus_s.op_data = 8'h00; bus_s.op_sub = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_acc", 32'(acc_s), 32'h00);
    check("rst_ovf_cnt", 32'({ovf_s, cnt_s}), 32'h0);
    check("rst_ctl", 32'({bus_s.op_rdy, busy_s, done_s}), 32'h0);

    // Frame 1: no overflow, back-to-back operands.
    do_start(8'hA5);
    check("start_rdy", 32'({bus_s.op_rdy, busy_s}), 32'h3);
    send(8'h5A, 1'b0, 8'hFF, 1'b0, 4'd1);
    send(8'hFF, 1'b1, 8'h00, 1'b0, 4'd2);
    send(8'h01, 1'b0, 8'h01, 1'b0, 4'd3);
    done_q.push_back('{acc: 8'h03, ovf: 1'b0, cnt: 4'd4});
    send(8'h02, 1'b0, 8'h03, 1'b0, 4'd4);
    check("f1_done_rdy", 32'({done_s, bus_s.op_rdy, busy_s}), 32'h4);
    check("f1_wrap_acc", 32'(acc_w), 32'h03);
    step();
    check("f1_idle", 32'({done_s, bus_s.op_rdy, busy_s}), 32'h0);

    // Frame 2: positive overflow saturates, flag stays sticky.
    do_start(8'h5A);
    send(8'h5A, 1'b0, 8'h7F, 1'b1, 4'd1);
    check("wrap_ovf_acc", 32'({acc_w, ovf_w}), 32'({8'hB4, 1'b1}));
    send(8'h01, 1'b1, 8'h7E, 1'b1, 4'd2);
    send(8'h00, 1'b0, 8'h7E, 1'b1, 4'd3);
    done_q.push_back('{acc: 8'h7E, ovf: 1'b1, cnt: 4'd4});
    send(8'h00, 1'b0, 8'h7E, 1'b1, 4'd4);
    step();

    // Frame 3: negative saturation, restart with a dropped operand, stalls, reset.
    do_start(8'h80);
    send(8'h01, 1'b1, 8'h80, 1'b1, 4'd1);
    bus_s.op_vld = 1'b1; bus_s.op_data = 8'h7F; bus_s.op_sub = 1'b0;
    start = 1'b1; init = 8'h10;
    step();
    start = 1'b0; bus_s.op_vld = 1'b0;
    check("restart_acc", 32'(acc_s), 32'h10);
    check("restart_ovf_cnt_rdy", 32'({ovf_s, cnt_s, bus_s.op_rdy}), 32'({1'b0, 4'd0, 1'b1}));
    do_start(8'h7F);
    send(8'h7F, 1'b0, 8'h7F, 1'b1, 4'd1);
    send(8'h01, 1'b1, 8'h7E, 1'b1, 4'd2);
    step(); step();
    check("stall_hold", 32'({acc_s, cnt_s}), 32'({8'h7E, 4'd2}));
    send(8'h01, 1'b0, 8'h7F, 1'b1, 4'd3);
    rst = 1'b1; bus_s.op_vld = 1'b1; bus_s.op_data = 8'h01;
    step();
    rst = 1'b0;
    check("midrst_acc_ovf_cnt", 32'({acc_s, ovf_s, cnt_s}), 32'h0);
    check("midrst_ctl", 32'({bus_s.op_rdy, busy_s, done_s}), 32'h0);
    step(); step();
    check("idle_no_accept", 32'({acc_s, cnt_s, bus_s.op_rdy}), 32'h0);

    // Frame 4: start alongside an operand in IDLE, then start during DONE.
    bus_s.op_data = 8'h05;
    start = 1'b1; init = 8'h22;
    step();
    start = 1'b0; bus_s.op_vld = 1'b0;
    check("idle_start_drop", 32'({acc_s, cnt_s}), 32'({8'h22, 4'd0}));
    send(8'h01, 1'b0, 8'h23, 1'b0, 4'd1);
    send(8'h03, 1'b1, 8'h20, 1'b0, 4'd2);
    send(8'h10, 1'b0, 8'h30, 1'b0, 4'd3);
    done_q.push_back('{acc: 8'h00, ovf: 1'b0, cnt: 4'd4});
    send(8'h30, 1'b1, 8'h00, 1'b0, 4'd4);
    start = 1'b1; init = 8'h33;
    step();
    start = 1'b0;
    check("done_start_ignored", 32'({acc_s, cnt_s, bus_s.op_rdy, busy_s}), 32'({8'h00, 4'd4, 2'b00}));
    step();
    check("done_start_stays_idle", 32'({bus_s.op_rdy, busy_s}), 32'h0);
    step(); step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
